// File: rtl/mem_store_fmt_pkg.sv
// mem_store_fmt_pkg
// Definitions shared by the store formatter and its lane-align helper.
//   XLEN    : register / memory data width (64 only)
//   STRB_W  : byte-strobe width of one memory beat
//   unit_e  : access-unit encoding, identical to the load path (B/HW/W/DW = 0/1/2/3)
//   state_e : store formatter sequencing states
package mem_store_fmt_pkg;

    localparam int XLEN   = 64;
    localparam int STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        UNIT_B  = 2'd0,
        UNIT_HW = 2'd1,
        UNIT_W  = 2'd2,
        UNIT_DW = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_store_fmt_lane_align.sv
// store_lane_align
// Purely combinational byte-lane placement of one store.  The store is
// viewed against a 16-byte window starting at the 8-byte-aligned base, so
// the low half belongs to the first memory beat and the high half to the
// second one (only used when the store spills past the 8-byte boundary).
//   off    : addr[2:0], byte offset inside the first beat
//   unit   : access unit (B/HW/W/DW)
//   data   : LSB-justified store data, bytes above the access size ignored
//   strb16 : byte enables over the 16-byte window
//   wd128  : lane-shifted data over the 16-byte window
//   split  : store touches the second beat
module store_lane_align
    import mem_store_fmt_pkg::*;
(
    input  logic [2:0]          off,
    input  unit_e               unit,
    input  logic [XLEN-1:0]     data,
    output logic [2*STRB_W-1:0] strb16,
    output logic [2*XLEN-1:0]   wd128,
    output logic                split
);

    logic [XLEN-1:0]     data_trunc;
    logic [2*STRB_W-1:0] size_mask;

    // Truncate the data to the access size and build the unshifted strobe
    // mask, then slide both up by the byte offset inside the window.
    always_comb begin
        data_trunc = '0;
        size_mask  = '0;
        case (unit)
            UNIT_B: begin
                data_trunc = {56'd0, data[7:0]};
                size_mask  = 16'h0001;
            end
            UNIT_HW: begin
                data_trunc = {48'd0, data[15:0]};
                size_mask  = 16'h0003;
            end
            UNIT_W: begin
                data_trunc = {32'd0, data[31:0]};
                size_mask  = 16'h000F;
            end
            default: begin
                data_trunc = data;
                size_mask  = 16'h00FF;
            end
        endcase
        strb16 = size_mask << off;
        wd128  = {{XLEN{1'b0}}, data_trunc} << {off, 3'b000};
        split  = |strb16[2*STRB_W-1:STRB_W];
    end

endmodule

// File: rtl/mem_store_fmt.sv
// mem_store_fmt
// Store-path formatter between MEM-stage store issue and the data-memory
// write port.  A captured store is turned into one or two 8-byte-aligned
// write beats with byte strobes; a store spilling past an 8-byte boundary
// takes two beats.  A single-cycle done pulse follows the last beat.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : store request valid
//   req_ready   : request accepted this cycle (only while idle)
//   req_addr    : byte address of the store
//   req_data    : LSB-justified store data
//   req_unit    : access unit (B/HW/W/DW = 0/1/2/3)
//   mem_wvalid  : write beat valid
//   mem_wready  : memory accepts the beat
//   mem_waddr   : 8-byte-aligned beat address
//   mem_wdata   : lane-shifted beat data
//   mem_wstrb   : byte enables, bit i = lane i
//   done        : one-cycle pulse after the final beat is accepted
//   split       : current store needs two beats (meaningful while mem_wvalid)
module mem_store_fmt
    import mem_store_fmt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_data,
    input  logic [1:0]        req_unit,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [XLEN-1:0]   mem_waddr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic              done,
    output logic              split
);

    state_e state_q, state_d;

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] data_q;
    unit_e           unit_q;

    logic [2*STRB_W-1:0] strb16;
    logic [2*XLEN-1:0]   wd128;
    logic                split_c;
    logic [XLEN-1:0]     base_addr;

    assign base_addr = {addr_q[XLEN-1:3], 3'b000};

    store_lane_align u_lane_align (
        .off    (addr_q[2:0]),
        .unit   (unit_q),
        .data   (data_q),
        .strb16 (strb16),
        .wd128  (wd128),
        .split  (split_c)
    );

    // State register; reset abandons any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture: only in IDLE, so the payload stays frozen for the
    // whole lifetime of the store, including backpressured beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            unit_q <= UNIT_B;
        end else if (req_valid && (state_q == ST_IDLE)) begin
            addr_q <= req_addr;
            data_q <= req_data;
            unit_q <= unit_e'(req_unit);
        end
    end

    // Next-state sequencing.  mem_wready only matters in the beat states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid)  state_d = ST_BEAT0;
            ST_BEAT0: if (mem_wready) state_d = split_c ? ST_BEAT1 : ST_DONE;
            ST_BEAT1: if (mem_wready) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from the state register and captured request only.
    // The payload is forced to zero outside the beat states so idle and
    // reset present a quiet bus.
    always_comb begin
        req_ready  = 1'b0;
        mem_wvalid = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        done       = 1'b0;
        split      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_BEAT0: begin
                mem_wvalid = 1'b1;
                mem_waddr  = base_addr;
                mem_wdata  = wd128[XLEN-1:0];
                mem_wstrb  = strb16[STRB_W-1:0];
                split      = split_c;
            end
            ST_BEAT1: begin
                mem_wvalid = 1'b1;
                mem_waddr  = base_addr + 64'd8;
                mem_wdata  = wd128[2*XLEN-1:XLEN];
                mem_wstrb  = strb16[2*STRB_W-1:STRB_W];
                split      = split_c;
            end
            default: begin
                done = 1'b1;
            end
        endcase
    end

endmodule
